// File: rtl/spi_flash_responder.sv
// ---------------------------------------------------------------------------
// spi_flash_responder
//
// SPI NOR-flash responder (mode 0, single-bit data lines). It stands in for a
// boot flash and answers READ (0x03), READ ID (0x9F) and READ STATUS (0x05)
// from an internal byte memory. The memory is loaded through the backdoor
// port.
//
// All SPI pins are oversampled with clk, and there is no logic in the SCLK
// domain. SCLK must be no faster than clk/4.
//
// Optional feature: define SPI_FLASH_FAST_READ_EN to accept FAST READ (0x0B).
// This command takes 24 address bits, then 8 dummy clocks, then streams data
// like 0x03. With the macro undefined, 0x0B is treated as unrecognised.
//
// Parameters
//   MEM_DEPTH  memory size in bytes (power of 2, >= 256)
//   INIT_FILE  memory image name; the memory starts zeroed
//   JEDEC_ID   three ID bytes returned by 0x9F, MSB first
//
// Ports
//   clk        system clock
//   rstn       asynchronous active-low reset
//   i_sclk     SPI clock from master (asynchronous to clk)
//   i_cs_n     SPI chip select, active low
//   i_mosi     SPI data from master
//   o_miso     SPI data to master
//   o_miso_oe  high while the responder drives o_miso
//   i_ld_en    backdoor byte write strobe
//   i_ld_addr  backdoor byte address
//   i_ld_data  backdoor write data
//   o_busy     high while a transaction is in progress
//   o_cmd_cnt  completed recognised commands (wraps)
// ---------------------------------------------------------------------------
module spi_flash_responder #(
    parameter int          MEM_DEPTH = 4096,
    parameter              INIT_FILE = "",
    parameter logic [23:0] JEDEC_ID  = 24'hEF4018
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_sclk,
    input  logic                         i_cs_n,
    input  logic                         i_mosi,
    output logic                         o_miso,
    output logic                         o_miso_oe,
    input  logic                         i_ld_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_ld_addr,
    input  logic [7:0]                   i_ld_data,
    output logic                         o_busy,
    output logic [15:0]                  o_cmd_cnt
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_ID,
        S_STAT,
        S_IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. sclk and cs_n get a third flop for edge
    // detection. All three pins have equal latency, so their relative
    // timing is preserved.
    // ------------------------------------------------------------------
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic cs_s1_q, cs_s2_q, cs_s3_q;
    logic mosi_s1_q, mosi_s2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_s3_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sclk_s1_q <= i_sclk;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            cs_s1_q   <= i_cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_s3_q   <= cs_s2_q;
            mosi_s1_q <= i_mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    logic sclk_rise, sclk_fall, cs_fall;
    assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
    assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
    assign cs_fall   = ~cs_s2_q & cs_s3_q;

    // ------------------------------------------------------------------
    // Byte memory with a registered read of mem[ptr]. The read runs every
    // clk, so the byte for the next fall is always ready. A backdoor write
    // to the address being read bypasses to the new data.
    // ------------------------------------------------------------------
    logic [7:0]    mem [MEM_DEPTH];
    logic [7:0]    rd_data_q;
    logic [AW-1:0] ptr_q, ptr_d;

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (i_ld_en) begin
            mem[i_ld_addr] <= i_ld_data;
        end
        if (i_ld_en && (i_ld_addr == ptr_q)) begin
            rd_data_q <= i_ld_data;
        end else begin
            rd_data_q <= mem[ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM and datapath registers.
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;    // SCLK rises in CMD/ADDR/DUMMY
    logic [AW-2:0] sr_q, sr_d;              // MOSI shift register
    logic [2:0]    fcnt_q, fcnt_d;          // SCLK falls within an output byte
    logic [1:0]    id_idx_q, id_idx_d;      // ID byte index, saturates at 3
    logic          fast_q, fast_d;          // command was FAST READ
    logic          miso_q, miso_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic [15:0]   cmd_cnt_q, cmd_cnt_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            ptr_q     <= '0;
            fcnt_q    <= '0;
            id_idx_q  <= '0;
            fast_q    <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            cmd_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            ptr_q     <= ptr_d;
            fcnt_q    <= fcnt_d;
            id_idx_q  <= id_idx_d;
            fast_q    <= fast_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            cmd_cnt_q <= cmd_cnt_d;
        end
    end

    logic [7:0] cmd_byte;
    logic [7:0] tx_byte;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        ptr_d     = ptr_q;
        fcnt_d    = fcnt_q;
        id_idx_d  = id_idx_q;
        fast_d    = fast_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        cmd_cnt_d = cmd_cnt_q;
        cmd_byte  = {sr_q[6:0], mosi_s2_q};

        // Byte being serialised in the current output state.
        tx_byte = 8'h00;
        case (state_q)
            S_DATA: tx_byte = rd_data_q;
            S_ID: begin
                case (id_idx_q)
                    2'd0:    tx_byte = JEDEC_ID[23:16];
                    2'd1:    tx_byte = JEDEC_ID[15:8];
                    2'd2:    tx_byte = JEDEC_ID[7:0];
                    default: tx_byte = 8'h00;
                endcase
            end
            default: tx_byte = 8'h00;
        endcase

        if (cs_s2_q) begin
            // Deselect ends any transaction at once. Partial bytes are dropped.
            // A command is counted only if it reached an output state.
            if ((state_q == S_DATA) || (state_q == S_ID) || (state_q == S_STAT)) begin
                cmd_cnt_d = cmd_cnt_q + 16'd1;
            end
            state_d   = S_IDLE;
            bit_cnt_d = '0;
            sr_d      = '0;
            fcnt_d    = '0;
            id_idx_d  = '0;
            fast_d    = 1'b0;
            miso_d    = 1'b0;
            oe_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d   = S_CMD;
                        bit_cnt_d = '0;
                    end
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        sr_d = {sr_q[AW-3:0], mosi_s2_q};
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            case (cmd_byte)
                                8'h03: state_d = S_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                                8'h0B: begin
                                    state_d = S_ADDR;
                                    fast_d  = 1'b1;
                                end
`endif
                                8'h9F:   state_d = S_ID;
                                8'h05:   state_d = S_STAT;
                                default: state_d = S_IGNORE;
                            endcase
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (sclk_rise) begin
                        sr_d = {sr_q[AW-3:0], mosi_s2_q};
                        if (bit_cnt_q == 5'd23) begin
                            // Only the low AW address bits are kept, which
                            // gives the modulo-MEM_DEPTH wrap for free.
                            ptr_d     = {sr_q, mosi_s2_q};
                            bit_cnt_d = '0;
                            state_d   = fast_q ? S_DUMMY : S_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                S_DUMMY: begin
                    if (sclk_rise) begin
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            state_d   = S_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                S_DATA, S_ID, S_STAT: begin
                    if (sclk_fall) begin
                        miso_d = tx_byte[3'd7 - fcnt_q];
                        oe_d   = 1'b1;
                        fcnt_d = fcnt_q + 3'd1;
                        if (fcnt_q == 3'd7) begin
                            if (state_q == S_DATA) begin
                                ptr_d = ptr_q + 1'b1;
                            end
                            if ((state_q == S_ID) && (id_idx_q != 2'd3)) begin
                                id_idx_d = id_idx_q + 2'd1;
                            end
                        end
                    end
                end
                S_IGNORE: begin
                    miso_d = 1'b0;
                    oe_d   = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    assign o_miso    = miso_q;
    assign o_miso_oe = oe_q;
    assign o_busy    = busy_q;
    assign o_cmd_cnt = cmd_cnt_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_flash_responder
//
// Directed bench for spi_flash_responder. A behavioural mode-0 master runs on
// negedges of clk with SCLK = clk/12, and expected values are hand-computed.
// Prints one line per SPI transaction and one summary line.
// ---------------------------------------------------------------------------
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        ld_en = 1'b0;
    logic [11:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic        miso, miso_oe, busy;
    logic [15:0] cmd_cnt;

    spi_flash_responder #(
        .MEM_DEPTH (4096),
        .INIT_FILE (""),
        .JEDEC_ID  (24'hEF4018)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_sclk    (sclk),
        .i_cs_n    (cs_n),
        .i_mosi    (mosi),
        .o_miso    (miso),
        .o_miso_oe (miso_oe),
        .i_ld_en   (ld_en),
        .i_ld_addr (ld_addr),
        .i_ld_data (ld_data),
        .o_busy    (busy),
        .o_cmd_cnt (cmd_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    logic [7:0] rx_buf [8];
    logic       hdr_oe_any;
    logic       data_oe_all;
    logic       data_oe_any;
    logic       busy_mid;
    int         busy_lat;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic backdoor(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Shift nbits (MSB first) of tx. MISO and OE are sampled just before
    // each rise, which is when a mode-0 master samples them.
    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic oe_all, output logic oe_any);
        rx     = 8'h00;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (6) @(negedge clk);
            rx[i]  = miso;
            oe_all = oe_all & miso_oe;
            oe_any = oe_any | miso_oe;
            sclk   = 1'b1;
            repeat (6) @(negedge clk);
            sclk   = 1'b0;
        end
    endtask

    // Full transaction: command, n_hdr header bytes (three address bytes,
    // then zero dummy bytes), n_rx read bytes, deselect.
    task automatic run_txn(input string name, input logic [7:0] cmd, input int n_hdr,
                           input logic [23:0] addr, input int n_rx);
        logic [7:0] rx;
        logic       a, o;
        logic [7:0] hb;
        hdr_oe_any  = 1'b0;
        data_oe_all = 1'b1;
        data_oe_any = 1'b0;
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(cmd, 8, rx, a, o);
        hdr_oe_any = hdr_oe_any | o;
        for (int b = 0; b < n_hdr; b++) begin
            hb = (b < 3) ? addr[23 - 8*b -: 8] : 8'h00;
            spi_bits(hb, 8, rx, a, o);
            hdr_oe_any = hdr_oe_any | o;
        end
        busy_mid = busy;
        for (int b = 0; b < n_rx; b++) begin
            spi_bits(8'h00, 8, rx, a, o);
            rx_buf[b]   = rx;
            data_oe_all = data_oe_all & a;
            data_oe_any = data_oe_any | o;
        end
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        busy_lat = 0;
        while (busy && busy_lat < 10) begin
            @(negedge clk);
            busy_lat++;
        end
        repeat (6) @(negedge clk);
        $display("txn %s cmd=%02h addr=%06h rx=%02h %02h %02h %02h %02h oe_all=%0b cnt=%0d",
                 name, cmd, addr, rx_buf[0], rx_buf[1], rx_buf[2], rx_buf[3], rx_buf[4],
                 data_oe_all, cmd_cnt);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        logic       a, o;

        for (int i = 0; i < 8; i++) rx_buf[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_miso", miso, 0);
        check_eq("rst_oe", miso_oe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cnt", cmd_cnt, 0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        backdoor(12'h010, 8'hDE);
        backdoor(12'h011, 8'hAD);
        backdoor(12'h012, 8'hBE);
        backdoor(12'h013, 8'hEF);
        backdoor(12'hFFF, 8'h5A);
        backdoor(12'h000, 8'hA5);

        // Plain READ
        run_txn("READ", 8'h03, 3, 24'h000010, 4);
        exp_cnt++;
        check_eq("rd_b0", rx_buf[0], 8'hDE);
        check_eq("rd_b1", rx_buf[1], 8'hAD);
        check_eq("rd_b2", rx_buf[2], 8'hBE);
        check_eq("rd_b3", rx_buf[3], 8'hEF);
        check_eq("rd_oe", data_oe_all, 1);
        check_eq("rd_hdr_oe", hdr_oe_any, 0);
        check_eq("rd_busy_mid", busy_mid, 1);
        check_eq("rd_busy_end", busy, 0);
        check_eq("rd_cnt", cmd_cnt, exp_cnt);

        // Wrap at the end of memory, and modulo addressing
        run_txn("WRAP", 8'h03, 3, 24'h000FFF, 2);
        exp_cnt++;
        check_eq("wrap_b0", rx_buf[0], 8'h5A);
        check_eq("wrap_b1", rx_buf[1], 8'hA5);
        run_txn("MOD", 8'h03, 3, 24'h001FFF, 1);
        exp_cnt++;
        check_eq("mod_b0", rx_buf[0], 8'h5A);
        check_eq("mod_cnt", cmd_cnt, exp_cnt);

        // READ ID and READ STATUS
        run_txn("ID", 8'h9F, 0, 24'h0, 5);
        exp_cnt++;
        check_eq("id_b0", rx_buf[0], 8'hEF);
        check_eq("id_b1", rx_buf[1], 8'h40);
        check_eq("id_b2", rx_buf[2], 8'h18);
        check_eq("id_b3", rx_buf[3], 8'h00);
        check_eq("id_b4", rx_buf[4], 8'h00);
        check_eq("id_oe", data_oe_all, 1);
        run_txn("STAT", 8'h05, 0, 24'h0, 2);
        exp_cnt++;
        check_eq("stat_b0", rx_buf[0], 8'h00);
        check_eq("stat_b1", rx_buf[1], 8'h00);
        check_eq("stat_oe", data_oe_all, 1);
        check_eq("stat_cnt", cmd_cnt, exp_cnt);

        // Unrecognised command
        run_txn("IGN", 8'hAB, 0, 24'h0, 2);
        check_eq("ign_oe", data_oe_any | hdr_oe_any, 0);
        check_eq("ign_cnt", cmd_cnt, exp_cnt);
        check_eq("ign_busy_lat_ok", busy_lat <= 3, 1);

        // Aborted READ after 12 address bits, then a clean READ
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(8'h03, 8, rx, a, o);
        spi_bits(8'h00, 8, rx, a, o);
        spi_bits(8'h00, 4, rx, a, o);
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        $display("txn ABORT cmd=03 addr bits=12 busy=%0b cnt=%0d", busy, cmd_cnt);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_cnt", cmd_cnt, exp_cnt);
        run_txn("READ2", 8'h03, 3, 24'h000010, 4);
        exp_cnt++;
        check_eq("rd2_b0", rx_buf[0], 8'hDE);
        check_eq("rd2_b1", rx_buf[1], 8'hAD);
        check_eq("rd2_b2", rx_buf[2], 8'hBE);
        check_eq("rd2_b3", rx_buf[3], 8'hEF);
        check_eq("rd2_cnt", cmd_cnt, exp_cnt);

        // FAST READ: three address bytes plus one dummy byte
        run_txn("FAST", 8'h0B, 4, 24'h000010, 2);
`ifdef SPI_FLASH_FAST_READ_EN
        exp_cnt++;
        check_eq("fast_b0", rx_buf[0], 8'hDE);
        check_eq("fast_b1", rx_buf[1], 8'hAD);
        check_eq("fast_hdr_oe", hdr_oe_any, 0);
        check_eq("fast_oe", data_oe_all, 1);
`else
        check_eq("fast_oe", data_oe_any | hdr_oe_any, 0);
`endif
        check_eq("fast_cnt", cmd_cnt, exp_cnt);

        // Asynchronous reset in the middle of the data phase
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(8'h03, 8, rx, a, o);
        spi_bits(8'h00, 8, rx, a, o);
        spi_bits(8'h00, 8, rx, a, o);
        spi_bits(8'h10, 8, rx, a, o);
        spi_bits(8'h00, 8, rx, a, o);   // reads 0xDE
        repeat (6) @(negedge clk);      // bit 7 of 0xAD is now on MISO
        check_eq("pre_rst_miso", miso, 1);
        check_eq("pre_rst_oe", miso_oe, 1);
        check_eq("pre_rst_busy", busy, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("arst_miso", miso, 0);
        check_eq("arst_oe", miso_oe, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_cnt", cmd_cnt, 0);
        $display("txn ARST mid-data miso=%0b oe=%0b busy=%0b cnt=%0d", miso, miso_oe, busy, cmd_cnt);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
